// File: rtl/riscv_v_pkg.sv
// Shared types and defaults for the vector pipeline stage controllers.
package riscv_v_pkg;

    localparam int RISCV_V_PIPE_STAGES  = 4;
    localparam int RISCV_V_FLUSH_CYCLES = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } riscv_v_stage_ctrl_state_e;

endpackage

// File: rtl/riscv_v_stage_ctrl_if.sv
// Handshake, stall/flush request and per-stage strobe bundle of one pipe segment controller.
interface riscv_v_stage_ctrl_if
    import riscv_v_pkg::*;
#(
    parameter int NUM_STAGES = RISCV_V_PIPE_STAGES,
    parameter int IDX_W      = $clog2(NUM_STAGES + 1)
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [NUM_STAGES-1:0] stall_req;
    logic                  flush_req;
    logic [IDX_W-1:0]      flush_stage;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_flush;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  flush_busy;
    logic [15:0]           stall_cnt;

    modport master (
        output in_valid, out_ready, stall_req, flush_req, flush_stage,
        input  in_ready, out_valid, stage_en, stage_flush, stage_valid, flush_busy, stall_cnt
    );

    modport slave (
        input  in_valid, out_ready, stall_req, flush_req, flush_stage,
        output in_ready, out_valid, stage_en, stage_flush, stage_valid, flush_busy, stall_cnt
    );

endinterface

// File: rtl/riscv_v_stage_hold_chain.sv
// Tail-to-head hold resolution: a stage holds on its own stall, or when it is
// occupied and its successor holds. Empty stages never hold for downstream reasons.
module riscv_v_stage_hold_chain
    import riscv_v_pkg::*;
#(
    parameter int NUM_STAGES = RISCV_V_PIPE_STAGES
) (
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic [NUM_STAGES-1:0] valid,
    input  logic                  out_ready,
    output logic [NUM_STAGES-1:0] hold
);

    // Resolve hold from the oldest stage toward the youngest.
    always_comb begin
        hold = '0;
        hold[NUM_STAGES-1] = stall_req[NUM_STAGES-1] | (valid[NUM_STAGES-1] & ~out_ready);
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            hold[i] = stall_req[i] | (valid[i] & hold[i+1]);
        end
    end

endmodule

// File: rtl/riscv_v_stage_ctrl.sv
// Enable/flush controller for a chain of vector pipeline stages: per-stage valid
// tracking, backpressure resolution and multi-cycle flush sequencing.
module riscv_v_stage_ctrl
    import riscv_v_pkg::*;
#(
    parameter int NUM_STAGES   = RISCV_V_PIPE_STAGES,
    parameter int FLUSH_CYCLES = RISCV_V_FLUSH_CYCLES,
    parameter int IDX_W        = $clog2(NUM_STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_v_stage_ctrl_if.slave  bus
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [IDX_W-1:0] DEPTH_MAX  = IDX_W'(NUM_STAGES);

    riscv_v_stage_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      depth_q, depth_d;
    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;

    logic [NUM_STAGES-1:0] hold_s;
    logic [NUM_STAGES-1:0] flush_mask_s;
    logic [NUM_STAGES-1:0] stage_en_s;
    logic [NUM_STAGES-1:0] up_valid_s;
    logic [IDX_W-1:0]      req_depth_s;
    logic [IDX_W-1:0]      eff_depth_s;
    logic                  in_ready_s;
    logic                  accept_s;

    riscv_v_stage_hold_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_hold_chain (
        .stall_req (bus.stall_req),
        .valid     (valid_q),
        .out_ready (bus.out_ready),
        .hold      (hold_s)
    );

    // Flush depth for this cycle: a new request merges with any flush in progress.
    always_comb begin
        req_depth_s = '0;
        eff_depth_s = '0;
        if (bus.flush_req && (bus.flush_stage != '0)) begin
            if (bus.flush_stage > DEPTH_MAX) begin
                req_depth_s = DEPTH_MAX;
            end else begin
                req_depth_s = bus.flush_stage;
            end
        end else begin
            req_depth_s = '0;
        end
        if ((state_q == FLUSH) && (depth_q > req_depth_s)) begin
            eff_depth_s = depth_q;
        end else begin
            eff_depth_s = req_depth_s;
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
            flush_mask_s[i] = ~rst & (IDX_W'(i + 1) <= eff_depth_s);
        end
    end

    assign stage_en_s = ~hold_s & ~flush_mask_s & {NUM_STAGES{~rst}};
    assign in_ready_s = ~hold_s[0] & (state_q == IDLE) & ~bus.flush_req & ~rst;
    assign accept_s   = bus.in_valid & in_ready_s;

    // Stage valid advance; a stage whose predecessor did not move loads a bubble.
    always_comb begin
        up_valid_s    = '0;
        up_valid_s[0] = accept_s;
        for (int i = 1; i < NUM_STAGES; i++) begin
            up_valid_s[i] = valid_q[i-1] & stage_en_s[i-1];
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (flush_mask_s[i]) begin
                valid_d[i] = 1'b0;
            end else if (stage_en_s[i]) begin
                valid_d[i] = up_valid_s[i];
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
        if (bus.in_valid && !in_ready_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Flush sequencer: the request cycle flushes too, then FLUSH_CYCLES-1 more cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        case (state_q)
            IDLE: begin
                if ((req_depth_s != '0) && (CNT_RELOAD != '0)) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_RELOAD;
                    depth_d = req_depth_s;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (req_depth_s != '0) begin
                    cnt_d   = CNT_RELOAD;
                    depth_d = eff_depth_s;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    depth_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                depth_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            depth_q     <= '0;
            valid_q     <= '0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            depth_q     <= depth_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = valid_q[NUM_STAGES-1];
    assign bus.stage_en    = stage_en_s;
    assign bus.stage_flush = flush_mask_s;
    assign bus.stage_valid = valid_q;
    assign bus.flush_busy  = (state_q == FLUSH);
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_riscv_v_stage_ctrl.sv
// Directed bench for riscv_v_stage_ctrl with N=4, FLUSH_CYCLES=2.
module tb_riscv_v_stage_ctrl;
    import riscv_v_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [3:0] exp_fill [10];

    riscv_v_stage_ctrl_if #(.NUM_STAGES(4)) bus ();

    riscv_v_stage_ctrl #(
        .NUM_STAGES   (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_fill[0] = 4'h1; exp_fill[1] = 4'h3; exp_fill[2] = 4'h7; exp_fill[3] = 4'hF;
        exp_fill[4] = 4'hF; exp_fill[5] = 4'hF; exp_fill[6] = 4'hE; exp_fill[7] = 4'hC;
        exp_fill[8] = 4'h8; exp_fill[9] = 4'h0;

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.stall_req   = 4'b0000;
        bus.flush_req   = 1'b0;
        bus.flush_stage = 3'd0;
        tick();
        tick();
        check("rst_valid", bus.stage_valid, 4'h0);
        check("rst_en", bus.stage_en, 4'h0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_flush", bus.stage_flush, 4'h0);
        check("rst_busy", bus.flush_busy, 1'b0);
        check("rst_stall_cnt", bus.stall_cnt, 16'd0);

        // Streaming: 6 items, no stalls.
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = (k < 6) ? 1'b1 : 1'b0;
            settle();
            check("stream_en", bus.stage_en, 4'hF);
            if (k < 6) check("stream_in_ready", bus.in_ready, 1'b1);
            tick();
            check("stream_valid", bus.stage_valid, exp_fill[k]);
            check("stream_out_valid", bus.out_valid, ((k >= 3) && (k <= 8)) ? 1'b1 : 1'b0);
        end
        check("stream_stall_cnt", bus.stall_cnt, 16'd0);

        // Full pipe blocked by the consumer for 3 cycles.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("full_valid", bus.stage_valid, 4'hF);
        for (int k = 0; k < 3; k++) begin
            settle();
            check("block_en", bus.stage_en, 4'h0);
            check("block_in_ready", bus.in_ready, 1'b0);
            tick();
        end
        check("block_stall_cnt", bus.stall_cnt, 16'd3);
        check("block_valid", bus.stage_valid, 4'hF);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        settle();
        check("release_en", bus.stage_en, 4'hF);
        tick();
        check("release_valid", bus.stage_valid, 4'hE);
        tick();
        tick();
        tick();
        check("drain_valid", bus.stage_valid, 4'h0);
        check("drain_stall_cnt", bus.stall_cnt, 16'd3);

        // Stage-3 stall with stages 1-2 empty.
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("s3_setup_valid", bus.stage_valid, 4'hC);
        bus.stall_req = 4'b0100;
        bus.in_valid  = 1'b1;
        settle();
        check("s3_en_a", bus.stage_en, 4'b1011);
        check("s3_in_ready_a", bus.in_ready, 1'b1);
        tick();
        check("s3_bubble", bus.stage_valid, 4'b0101);
        check("s3_en_b", bus.stage_en, 4'b1011);
        tick();
        check("s3_fill", bus.stage_valid, 4'b0111);
        check("s3_en_c", bus.stage_en, 4'b1000);
        check("s3_in_ready_c", bus.in_ready, 1'b0);
        tick();
        check("s3_hold_valid", bus.stage_valid, 4'b0111);
        bus.stall_req = 4'b0000;
        bus.in_valid  = 1'b0;
        settle();
        check("s3_release_en", bus.stage_en, 4'hF);
        tick();
        check("s3_release_valid", bus.stage_valid, 4'b1110);
        check("s3_stall_cnt", bus.stall_cnt, 16'd4);
        tick();
        tick();
        tick();
        check("s3_drain", bus.stage_valid, 4'h0);

        // Flush depth 2 on a full streaming pipe.
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("f2_full", bus.stage_valid, 4'hF);
        bus.flush_req   = 1'b1;
        bus.flush_stage = 3'd2;
        settle();
        check("f2_flush_c0", bus.stage_flush, 4'b0011);
        check("f2_en_c0", bus.stage_en, 4'b1100);
        check("f2_in_ready_c0", bus.in_ready, 1'b0);
        check("f2_busy_c0", bus.flush_busy, 1'b0);
        tick();
        bus.flush_req = 1'b0;
        settle();
        check("f2_busy_c1", bus.flush_busy, 1'b1);
        check("f2_flush_c1", bus.stage_flush, 4'b0011);
        check("f2_in_ready_c1", bus.in_ready, 1'b0);
        check("f2_valid_c1", bus.stage_valid, 4'b1000);
        tick();
        check("f2_busy_end", bus.flush_busy, 1'b0);
        check("f2_flush_end", bus.stage_flush, 4'b0000);
        check("f2_in_ready_end", bus.in_ready, 1'b1);
        check("f2_valid_end", bus.stage_valid, 4'b0000);
        check("f2_stall_cnt", bus.stall_cnt, 16'd6);
        bus.in_valid = 1'b0;

        // Flush depth 1 extended to depth 3 one cycle later.
        bus.flush_req   = 1'b1;
        bus.flush_stage = 3'd1;
        settle();
        check("f13_flush_c0", bus.stage_flush, 4'b0001);
        tick();
        bus.flush_stage = 3'd3;
        settle();
        check("f13_flush_c1", bus.stage_flush, 4'b0111);
        check("f13_busy_c1", bus.flush_busy, 1'b1);
        tick();
        bus.flush_req = 1'b0;
        settle();
        check("f13_flush_c2", bus.stage_flush, 4'b0111);
        check("f13_busy_c2", bus.flush_busy, 1'b1);
        tick();
        check("f13_busy_end", bus.flush_busy, 1'b0);
        check("f13_flush_end", bus.stage_flush, 4'b0000);

        // Zero depth is ignored; oversized depth clamps to all stages.
        bus.flush_req   = 1'b1;
        bus.flush_stage = 3'd0;
        settle();
        check("f0_flush", bus.stage_flush, 4'b0000);
        tick();
        check("f0_busy", bus.flush_busy, 1'b0);
        bus.flush_stage = 3'd7;
        settle();
        check("fclamp_flush", bus.stage_flush, 4'b1111);
        tick();
        bus.flush_req = 1'b0;
        check("fclamp_busy", bus.flush_busy, 1'b1);
        tick();
        check("fclamp_busy_end", bus.flush_busy, 1'b0);

        // Reset in the middle of a flush with a full pipe.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        bus.in_valid    = 1'b0;
        bus.flush_req   = 1'b1;
        bus.flush_stage = 3'd2;
        tick();
        bus.flush_req = 1'b0;
        check("frst_valid_pre", bus.stage_valid, 4'b1100);
        check("frst_busy_pre", bus.flush_busy, 1'b1);
        check("frst_stall_cnt_pre", bus.stall_cnt, 16'd6);
        rst = 1'b1;
        settle();
        check("frst_flush_in_rst", bus.stage_flush, 4'b0000);
        tick();
        rst = 1'b0;
        settle();
        check("frst_valid", bus.stage_valid, 4'h0);
        check("frst_flush", bus.stage_flush, 4'h0);
        check("frst_busy", bus.flush_busy, 1'b0);
        check("frst_stall_cnt", bus.stall_cnt, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_v_stage_ctrl.md
Name: riscv_v_stage_ctrl

Overview:
Controller that drives the enable/flush side of a chain of vector pipeline data stages. It tracks one valid bit per stage, resolves per-stage stall backpressure from the tail toward the head, and sequences multi-cycle flushes. It produces the per-stage en/flush strobes and the valid/ready handshake at the pipe's head and tail. It sits beside each multi-stage vector datapath segment (decode→issue, issue→execute).

Parameters:
NUM_STAGES, 4, number of registered stages controlled (≥1); stage 1 = youngest (head), stage NUM_STAGES = oldest (tail)
FLUSH_CYCLES, 2, cycles stage_flush is held per flush request (≥1)
IDX_W, $clog2(NUM_STAGES+1), width of flush_stage index

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  new item presented to stage 1
in_ready  output  1  stage 1 accepts this cycle
out_valid  output  1  = stage_valid[NUM_STAGES]
out_ready  input  1  consumer takes tail item
stall_req  input  NUM_STAGES  bit i-1: stage i must hold (operand/hazard stall)
flush_req  input  1  flush request pulse
flush_stage  input  IDX_W  flush stages 1..flush_stage (0 = no-op, >NUM_STAGES clamped)
stage_en  output  NUM_STAGES  bit i-1: stage i loads from stage i-1
stage_flush  output  NUM_STAGES  bit i-1: stage i loads its flush value
stage_valid  output  NUM_STAGES  valid bit per stage
flush_busy  output  1  FSM in FLUSH
stall_cnt  output  16  saturating count of cycles with in_valid && !in_ready

Behaviour:
- Reset (rst=1 at edge): stage_valid=0, FSM=IDLE, flush counter=0, stall_cnt=0, stored flush depth=0. Outputs are combinational off this state: stage_en=0 (rst forces en low), stage_flush=0, in_ready=0 while rst high.
- Hold chain (combinational, tail first): hold[N] = stall_req[N] | (stage_valid[N] & ~out_ready); hold[i] = stall_req[i] | (stage_valid[i] & hold[i+1]) for i<N. An invalid stage never holds because of downstream (bubble collapse).
- stage_en[i] = ~hold[i] & ~rst & ~stage_flush[i]. On en: stage_valid[i] <= stage_valid[i-1] (stage 0 = in_valid & in_ready). Held stage keeps its valid.
- A stage that is not held but whose predecessor is held loads a bubble: valid <= 0, en still asserted.
- in_ready = ~hold[1] & (state==IDLE) & ~flush_req. Latency in→out with no stalls = NUM_STAGES cycles.
- FSM IDLE→FLUSH on flush_req with flush_stage≠0. Store depth d = min(flush_stage, N) and load counter = FLUSH_CYCLES-1. In FLUSH: stage_flush[i]=1 and stage_valid[i]<=0 for i≤d; decrement counter; at 0 → IDLE. The flush_req cycle itself also drives stage_flush (zero-cycle response). Total flush assertion = FLUSH_CYCLES cycles.
- Flush priority: flush > stall > enable. Stages i>d keep running the hold chain; stage d+1, if enabled, loads a bubble.
- flush_req while in FLUSH: d <= max(d, new depth); counter reloaded to FLUSH_CYCLES-1.
- flush_req with flush_stage=0: ignored.
- in_ready=0 throughout FLUSH.
- out_valid && out_ready with no hold retires the tail item the same cycle; the tail may refill simultaneously.
- stall_cnt saturates at 0xFFFF; only rst clears it.
- Reset mid-flush: returns to IDLE immediately; no residual stage_flush.

Decomposition:
- riscv_v_pkg: riscv_v_stage_ctrl_state_e {IDLE, FLUSH}; RISCV_V_PIPE_STAGES default; RISCV_V_FLUSH_CYCLES default.
- Sub-module riscv_v_stage_hold_chain: combinational tail-to-head hold resolution (stall_req, valid, out_ready → hold). Reused by other segment controllers.

Test Plan:
- N=4, no stalls, in_valid=1 for 6 cycles, out_ready=1 → out_valid first high 4 cycles after the first accept; 6 consecutive out_valid; stage_en=4'hF every cycle.
- Pipe full, out_ready=0 for 3 cycles → stage_en=0, in_ready=0, stall_cnt +=3; release → all stages advance next cycle, no item lost or duplicated.
- stall_req=4'b0100 (stage 3), stages 1–2 empty → stages 1–2 keep filling until valid, stage 4 drains, stage 4 valid=0 after one cycle (bubble inserted).
- flush_req, flush_stage=2, FLUSH_CYCLES=2, all valid → stage_flush=4'b0011 for 2 cycles, stage_valid[1:0]=0, stages 3–4 continue, in_ready=0 for 2 cycles, then IDLE.
- flush_req depth 1, then depth 3 one cycle later → stage_flush=4'b0111 for 2 further cycles (total 3 cycles), flush_busy falls after.
- rst asserted during FLUSH with full pipe → next cycle stage_valid=0, stage_flush=0, flush_busy=0, stall_cnt=0.
